// File: rtl/majority_n_bit.sv
// N-bit majority voter. It counts the ones on a bus through a balanced adder tree
// and flags when that count reaches N/2. It provides a combinational flag and registered flag/count copies.
module majority_n_bit #(
   parameter int N = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [N-1:0]                          in,
   output logic                                  out,
   output logic                                  out_q,
   output logic [((N < 2) ? 1 : $clog2(N+1))-1:0] count_q
);

   localparam int CW     = (N < 2) ? 1 : $clog2(N + 1);
   localparam int THRESH = N / 2;
   // Leaf count padded to a power of two so the tree is a complete binary heap.
   localparam int P      = (N <= 1) ? 1 : (1 << $clog2(N));
   localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

   logic [P-1:0]  in_pad;
   logic [CW-1:0] count_p0;

   assign in_pad = P'(in);

   // Heap layout: leaves at [P-1 .. 2P-2], node i sums its children 2i+1 and 2i+2.
   // Walking the indices downward builds each level from the one below it.
   // The result is log2(P) adder levels deep, not a ripple chain.
   always_comb begin : popcount_tree
      logic [CW-1:0] node [0:2*P-2];
      for (int i = 0; i < 2*P-1; i++) begin
         node[i] = '0;
      end
      for (int k = 0; k < P; k++) begin
         node[P-1+k] = CW'(in_pad[k]);
      end
      for (int i = P-2; i >= 0; i--) begin
         node[i] = node[2*i+1] + node[2*i+2];
      end
      count_p0 = node[0];
   end

   generate
      if (THRESH == 0) begin : g_always_true
         assign out = 1'b1;
      end else begin : g_compare
         assign out = (count_p0 >= THRESH_C);
      end
   endgenerate

   // Stage p0 -> registered outputs; reset clears them without waiting for clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= 1'b0;
         count_q <= '0;
      end else begin
         out_q   <= out;
         count_q <= count_p0;
      end
   end

endmodule

// File: tb/tb_majority_n_bit.sv
// Directed and model-checked vectors for majority_n_bit at N=16, N=5 and N=1.
module tb_majority_n_bit;

   logic        clk;
   logic        rst;
   logic [15:0] in16;
   logic [4:0]  in5;
   logic [0:0]  in1;
   logic        out16, out_q16;
   logic [4:0]  count_q16;
   logic        out5, out_q5;
   logic [2:0]  count_q5;
   logic        out1, out_q1;
   logic [0:0]  count_q1;

   int n_cmp = 0;
   int n_err = 0;

   majority_n_bit #(.N(16)) dut16 (
      .clk(clk), .rst(rst), .in(in16), .out(out16), .out_q(out_q16), .count_q(count_q16)
   );
   majority_n_bit #(.N(5)) dut5 (
      .clk(clk), .rst(rst), .in(in5), .out(out5), .out_q(out_q5), .count_q(count_q5)
   );
   majority_n_bit #(.N(1)) dut1 (
      .clk(clk), .rst(rst), .in(in1), .out(out1), .out_q(out_q1), .count_q(count_q1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int popcnt(input logic [15:0] v, input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += int'(v[i]);
      return s;
   endfunction

   task automatic apply16(input logic [15:0] v, input logic eo, input int ec);
      @(negedge clk);
      in16 = v;
      #1 check("out16", 32'(out16), 32'(eo));
      @(posedge clk);
      #1;
      check("out_q16", 32'(out_q16), 32'(eo));
      check("count_q16", 32'(count_q16), 32'(ec));
   endtask

   task automatic apply5(input logic [4:0] v, input logic eo, input int ec);
      @(negedge clk);
      in5 = v;
      #1 check("out5", 32'(out5), 32'(eo));
      @(posedge clk);
      #1;
      check("out_q5", 32'(out_q5), 32'(eo));
      check("count_q5", 32'(count_q5), 32'(ec));
   endtask

   task automatic apply1(input logic v, input int ec);
      @(negedge clk);
      in1 = v;
      #1 check("out1", 32'(out1), 32'd1);
      @(posedge clk);
      #1;
      check("out_q1", 32'(out_q1), 32'd1);
      check("count_q1", 32'(count_q1), 32'(ec));
   endtask

   initial begin
      logic [15:0] v16, prev16;
      logic [4:0]  v5, prev5;
      int          s;

      rst  = 1'b1;
      in16 = 16'h0000;
      in5  = 5'b00000;
      in1  = 1'b0;
      #7;
      check("rst_out_q16", 32'(out_q16), 32'd0);
      check("rst_count_q16", 32'(count_q16), 32'd0);
      check("rst_out16_comb", 32'(out16), 32'd0);
      check("rst_out1_comb", 32'(out1), 32'd1);
      check("rst_count_q5", 32'(count_q5), 32'd0);
      #5 rst = 1'b0;

      // N=16 directed
      apply16(16'h00FF, 1'b1, 8);
      apply16(16'h007F, 1'b0, 7);
      apply16(16'h0000, 1'b0, 0);
      apply16(16'hFFFF, 1'b1, 16);
      apply16(16'hAAAA, 1'b1, 8);
      apply16(16'h5554, 1'b0, 7);
      apply16(16'h8001, 1'b0, 2);
      apply16(16'hFF00, 1'b1, 8);

      // N=5 directed
      apply5(5'b00011, 1'b1, 2);
      apply5(5'b00001, 1'b0, 1);
      apply5(5'b00000, 1'b0, 0);
      apply5(5'b11111, 1'b1, 5);
      apply5(5'b10100, 1'b1, 2);

      // N=1 directed
      apply1(1'b0, 0);
      apply1(1'b1, 1);
      apply1(1'b0, 0);

      // Asynchronous reset mid-cycle with all ones on the bus
      apply16(16'hFFFF, 1'b1, 16);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_out_q16", 32'(out_q16), 32'd0);
      check("midrst_count_q16", 32'(count_q16), 32'd0);
      check("midrst_out16", 32'(out16), 32'd1);
      @(posedge clk);
      #1 check("midrst_hold_count_q16", 32'(count_q16), 32'd0);
      @(negedge clk);
      #1 rst = 1'b0;
      #1 check("postrst_hold_count_q16", 32'(count_q16), 32'd0);
      @(posedge clk);
      #1 check("postrst_count_q16", 32'(count_q16), 32'd16);
      check("postrst_out_q16", 32'(out_q16), 32'd1);

      // Model-checked vectors: comb against the current one, registered against the prior one
      prev16 = in16;
      prev5  = in5;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         v16 = 16'($urandom);
         v5  = 5'($urandom);
         in16 = v16;
         in5  = v5;
         #1;
         check("rq_count_q16", 32'(count_q16), 32'(popcnt(prev16, 16)));
         check("rq_out_q16", 32'(out_q16), (popcnt(prev16, 16) < 8) ? 32'd0 : 32'd1);
         check("rq_count_q5", 32'(count_q5), 32'(popcnt({11'd0, prev5}, 5)));
         s = popcnt(v16, 16);
         check("r_out16", 32'(out16), (s < 8) ? 32'd0 : 32'd1);
         s = popcnt({11'd0, v5}, 5);
         check("r_out5", 32'(out5), (s < 2) ? 32'd0 : 32'd1);
         @(posedge clk);
         prev16 = v16;
         prev5  = v5;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
